mux_scan_reg: RTL

Parametrised, registered N-channel data selector. It is the clocked successor to our 8-line TTL mux models, with the same active-low strobe and complementary outputs. Adds multi-bit channels, a configurable channel count and an auto-scan mode, in which an internal sequencer steps through the channels with a programmable dwell time. Intended for time-multiplexed display and bus-sampling paths in the TTL-derived designs.

---
 rtl/mux_scan_reg_if.sv | 31 +++
 rtl/mux_scan_reg.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mux_scan_reg_if.sv
// Bus bundle for the registered N-channel selector: strobe, mode, select,
// dwell and packed channel data in; selected word, complement, channel index
// and status pulses out.
interface mux_scan_reg_if #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL_W  = 4
);
    logic                         strobe_n;
    logic                         mode;
    logic [SEL_W-1:0]             sel;
    logic [DWELL_W-1:0]           dwell;
    logic [CHANNELS*WIDTH-1:0]    data;
    logic [WIDTH-1:0]             y;
    logic [WIDTH-1:0]             w;
    logic [SEL_W-1:0]             ch;
    logic                         valid;
    logic                         wrap;
    logic                         sel_err;

    modport master (
        output strobe_n, mode, sel, dwell, data,
        input  y, w, ch, valid, wrap, sel_err
    );

    modport slave (
        input  strobe_n, mode, sel, dwell, data,
        output y, w, ch, valid, wrap, sel_err
    );
endinterface

// File: rtl/mux_scan_reg.sv
// Registered N-channel data selector with active-low strobe, complementary
// outputs and an auto-scan sequencer that steps through the channels with a
// programmable dwell (dwell+1 cycles per channel).
module mux_scan_reg #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL_W  = 4
) (
    input logic           clk,
    input logic           reset_n,
    mux_scan_reg_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // One extra bit so CHANNELS itself is representable (e.g. 256 with SEL_W=8).
    localparam logic [SEL_W:0]   NUM_CH  = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    // Channel extraction; indices at or above CHANNELS yield zero.
    function automatic logic [WIDTH-1:0] pick(
        input logic [CHANNELS*WIDTH-1:0] d,
        input logic [SEL_W-1:0]          idx
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) begin
                r = d[k*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     ch_q, ch_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic                 valid_q, valid_d;
    logic                 wrap_q, wrap_d;
    logic                 sel_err_q, sel_err_d;
    logic                 sel_ok;

    assign sel_ok = ({1'b0, bus.sel} < NUM_CH);

    // Next-state and next-output decode; strobe inactive forces outputs off
    // and freezes channel, dwell counter and state.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        y_d       = '0;
        valid_d   = 1'b0;
        wrap_d    = 1'b0;
        sel_err_d = 1'b0;

        if (!bus.strobe_n) begin
            if (!bus.mode) begin
                // Direct select (also the landing rule when leaving scan).
                state_d = IDLE;
                cnt_d   = '0;
                if (sel_ok) begin
                    ch_d    = bus.sel;
                    y_d     = pick(bus.data, bus.sel);
                    valid_d = 1'b1;
                end else begin
                    sel_err_d = 1'b1;
                end
            end else if (state_q == IDLE) begin
                // Scan entry: start at sel, or channel 0 if sel is illegal.
                state_d = SCAN;
                ch_d    = sel_ok ? bus.sel : '0;
                cnt_d   = '0;
                y_d     = pick(bus.data, ch_d);
                valid_d = 1'b1;
            end else begin
                // >= so that shrinking dwell below the count advances at once.
                if (cnt_q >= bus.dwell) begin
                    cnt_d  = '0;
                    ch_d   = (ch_q == LAST_CH) ? '0 : ch_q + SEL_W'(1);
                    wrap_d = (ch_q == LAST_CH);
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
                y_d     = pick(bus.data, ch_d);
                valid_d = 1'b1;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            cnt_q     <= '0;
            y_q       <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.y       = y_q;
    assign bus.w       = ~y_q;
    assign bus.ch      = ch_q;
    assign bus.valid   = valid_q;
    assign bus.wrap    = wrap_q;
    assign bus.sel_err = sel_err_q;

endmodule
